// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the MIPS ALU control / multiply-divide unit.
// Op classes, funct codes, ALU operation codes and sequencer states.
package alu_ctrl_pkg;

   localparam logic [2:0] ALU_OP_RTYPE = 3'b111;
   localparam logic [2:0] ALU_OP_ADDI  = 3'b100;
   localparam logic [2:0] ALU_OP_LUI   = 3'b001;
   localparam logic [2:0] ALU_OP_ORI   = 3'b010;
   localparam logic [2:0] ALU_OP_ANDI  = 3'b011;

   localparam logic [5:0] FUNCT_ADD   = 6'b100000;
   localparam logic [5:0] FUNCT_SUB   = 6'b100010;
   localparam logic [5:0] FUNCT_OR    = 6'b100101;
   localparam logic [5:0] FUNCT_AND   = 6'b100100;
   localparam logic [5:0] FUNCT_SLT   = 6'b101010;
   localparam logic [5:0] FUNCT_SLL   = 6'b000000;
   localparam logic [5:0] FUNCT_SRL   = 6'b000010;
   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
   localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

   localparam logic [3:0] ALU_CTL_AND  = 4'b0000;
   localparam logic [3:0] ALU_CTL_SUB  = 4'b0001;
   localparam logic [3:0] ALU_CTL_OR   = 4'b0010;
   localparam logic [3:0] ALU_CTL_ADD  = 4'b0011;
   localparam logic [3:0] ALU_CTL_LUI  = 4'b0100;
   localparam logic [3:0] ALU_CTL_SLT  = 4'b0101;
   localparam logic [3:0] ALU_CTL_SLL  = 4'b0110;
   localparam logic [3:0] ALU_CTL_SRL  = 4'b0111;
   localparam logic [3:0] ALU_CTL_HILO = 4'b1000;
   localparam logic [3:0] ALU_CTL_NOP  = 4'b1001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } md_state_t;

endpackage

// File: rtl/md_iter_core.sv
// Unsigned iterative multiply/divide datapath: one shift-add or restoring
// shift-subtract step per clock, DATA_WIDTH steps per operation.
module md_iter_core #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_start,
   input  logic                  i_is_div,
   input  logic [DATA_WIDTH-1:0] i_a_mag,
   input  logic [DATA_WIDTH-1:0] i_b_mag,
   output logic                  o_busy,
   output logic                  o_last,
   output logic [DATA_WIDTH-1:0] o_nxt_hi,
   output logic [DATA_WIDTH-1:0] o_nxt_lo
);

   localparam int CW = $clog2(DATA_WIDTH + 1);

   logic [CW-1:0]         r_count;
   logic [DATA_WIDTH-1:0] r_hi;
   logic [DATA_WIDTH-1:0] r_lo;
   logic [DATA_WIDTH-1:0] r_b;

   logic [DATA_WIDTH:0]   w_sum;
   logic [DATA_WIDTH:0]   w_shift;
   logic [DATA_WIDTH+1:0] w_diff;

   // Multiply: r_hi is the partial product, r_lo holds the multiplier and
   // fills with product bits. Divide: r_hi is the remainder, r_lo shifts the
   // dividend out and quotient bits in.
   always_comb begin
      w_sum    = {1'b0, r_hi} + {1'b0, r_b};
      w_shift  = {r_hi, r_lo[DATA_WIDTH-1]};
      w_diff   = {1'b0, w_shift} - {2'b00, r_b};
      o_nxt_hi = r_hi;
      o_nxt_lo = r_lo;
      if (i_is_div) begin
         if (!w_diff[DATA_WIDTH+1]) begin
            o_nxt_hi = w_diff[DATA_WIDTH-1:0];
            o_nxt_lo = {r_lo[DATA_WIDTH-2:0], 1'b1};
         end else begin
            o_nxt_hi = w_shift[DATA_WIDTH-1:0];
            o_nxt_lo = {r_lo[DATA_WIDTH-2:0], 1'b0};
         end
      end else if (r_lo[0]) begin
         {o_nxt_hi, o_nxt_lo} = {w_sum, r_lo[DATA_WIDTH-1:1]};
      end else begin
         {o_nxt_hi, o_nxt_lo} = {1'b0, r_hi, r_lo[DATA_WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_b     <= '0;
      end else if (i_start) begin
         r_count <= CW'(DATA_WIDTH);
         r_hi    <= '0;
         r_lo    <= i_a_mag;
         r_b     <= i_b_mag;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
         r_hi    <= o_nxt_hi;
         r_lo    <= o_nxt_lo;
      end
   end

   assign o_busy = (r_count != '0);
   assign o_last = (r_count == CW'(1));

endmodule

// File: rtl/alu_control_md.sv
// MIPS ALU control with iterative MULT/DIV sequencer owning HI/LO,
// MFHI/MFLO/MTHI/MTLO service and pipeline stall generation.
module alu_control_md
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ALU_OP_WIDTH = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    valid_i,
   input  logic [ALU_OP_WIDTH-1:0] alu_op_i,
   input  logic [5:0]              alu_function_i,
   input  logic [DATA_WIDTH-1:0]   rs_data_i,
   input  logic [DATA_WIDTH-1:0]   rt_data_i,
   output logic [3:0]              alu_operation_o,
   output logic                    stall_o,
   output logic                    md_busy_o,
   output logic                    md_done_o,
   output logic [DATA_WIDTH-1:0]   hilo_data_o,
   output logic [DATA_WIDTH-1:0]   hi_o,
   output logic [DATA_WIDTH-1:0]   lo_o
);

   md_state_t r_state, w_nxt_state;

   logic [DATA_WIDTH-1:0] r_hi, r_lo;
   logic                  r_is_div, r_neg_res, r_neg_rem, r_div0;

   logic w_rtype, w_is_md, w_is_mf, w_is_mthi, w_is_mtlo;
   logic w_signed, w_div_op, w_accept, w_last, w_core_busy;
   logic [DATA_WIDTH-1:0]   w_a_mag, w_b_mag, w_nxt_hi, w_nxt_lo;
   logic [DATA_WIDTH-1:0]   w_res_hi, w_res_lo;
   logic [2*DATA_WIDTH-1:0] w_prod;

   assign w_rtype   = (alu_op_i == ALU_OP_WIDTH'(ALU_OP_RTYPE));
   assign w_is_md   = w_rtype && (alu_function_i == FUNCT_MULT  || alu_function_i == FUNCT_MULTU ||
                                  alu_function_i == FUNCT_DIV   || alu_function_i == FUNCT_DIVU);
   assign w_is_mf   = w_rtype && (alu_function_i == FUNCT_MFHI  || alu_function_i == FUNCT_MFLO);
   assign w_is_mthi = w_rtype && (alu_function_i == FUNCT_MTHI);
   assign w_is_mtlo = w_rtype && (alu_function_i == FUNCT_MTLO);
   assign w_signed  = (alu_function_i == FUNCT_MULT) || (alu_function_i == FUNCT_DIV);
   assign w_div_op  = (alu_function_i == FUNCT_DIV)  || (alu_function_i == FUNCT_DIVU);

   assign stall_o   = valid_i & md_busy_o & (w_is_md | w_is_mf | w_is_mthi | w_is_mtlo);
   assign w_accept  = valid_i & w_is_md & ~stall_o;

   assign w_a_mag = (w_signed && rs_data_i[DATA_WIDTH-1]) ? -rs_data_i : rs_data_i;
   assign w_b_mag = (w_signed && rt_data_i[DATA_WIDTH-1]) ? -rt_data_i : rt_data_i;

   always_comb begin
      alu_operation_o = ALU_CTL_NOP;
      case (alu_op_i)
         ALU_OP_WIDTH'(ALU_OP_RTYPE): begin
            case (alu_function_i)
               FUNCT_ADD:  alu_operation_o = ALU_CTL_ADD;
               FUNCT_SUB:  alu_operation_o = ALU_CTL_SUB;
               FUNCT_OR:   alu_operation_o = ALU_CTL_OR;
               FUNCT_AND:  alu_operation_o = ALU_CTL_AND;
               FUNCT_SLT:  alu_operation_o = ALU_CTL_SLT;
               FUNCT_SLL:  alu_operation_o = ALU_CTL_SLL;
               FUNCT_SRL:  alu_operation_o = ALU_CTL_SRL;
               FUNCT_MFHI,
               FUNCT_MFLO: alu_operation_o = ALU_CTL_HILO;
               default:    alu_operation_o = ALU_CTL_NOP;
            endcase
         end
         ALU_OP_WIDTH'(ALU_OP_ADDI): alu_operation_o = ALU_CTL_ADD;
         ALU_OP_WIDTH'(ALU_OP_LUI):  alu_operation_o = ALU_CTL_LUI;
         ALU_OP_WIDTH'(ALU_OP_ORI):  alu_operation_o = ALU_CTL_OR;
         ALU_OP_WIDTH'(ALU_OP_ANDI): alu_operation_o = ALU_CTL_AND;
         default:                    alu_operation_o = ALU_CTL_NOP;
      endcase
   end

   md_iter_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
      .clk      (clk),
      .reset    (reset),
      .i_start  (w_accept),
      .i_is_div (r_is_div),
      .i_a_mag  (w_a_mag),
      .i_b_mag  (w_b_mag),
      .o_busy   (w_core_busy),
      .o_last   (w_last),
      .o_nxt_hi (w_nxt_hi),
      .o_nxt_lo (w_nxt_lo)
   );

   // Sign fix-up on the final step's output; the product is negated as a whole
   // so the borrow propagates from LO into HI.
   always_comb begin
      w_prod   = {w_nxt_hi, w_nxt_lo};
      w_res_hi = w_nxt_hi;
      w_res_lo = w_nxt_lo;
      if (r_is_div) begin
         if (r_neg_rem) w_res_hi = -w_nxt_hi;
         if (r_neg_res) w_res_lo = -w_nxt_lo;
         if (r_div0)    w_res_lo = '1;
      end else begin
         if (r_neg_res) w_prod = -w_prod;
         {w_res_hi, w_res_lo} = w_prod;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nxt_state;
      end
   end

   always_comb begin
      w_nxt_state = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_nxt_state = ST_RUN;
         ST_RUN:  if (w_last)   w_nxt_state = ST_DONE;
         ST_DONE: w_nxt_state = w_accept ? ST_RUN : ST_IDLE;
         default: w_nxt_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_is_div  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_div0    <= 1'b0;
      end else if (w_accept) begin
         r_is_div  <= w_div_op;
         r_neg_res <= w_signed & (rs_data_i[DATA_WIDTH-1] ^ rt_data_i[DATA_WIDTH-1]);
         r_neg_rem <= w_signed & rs_data_i[DATA_WIDTH-1];
         r_div0    <= w_div_op & (rt_data_i == '0);
      end
   end

   // MTHI/MTLO stall while RUN, so they never collide with the result write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (r_state == ST_RUN && w_last) begin
         r_hi <= w_res_hi;
         r_lo <= w_res_lo;
      end else if (valid_i && !stall_o) begin
         if (w_is_mthi) r_hi <= rs_data_i;
         if (w_is_mtlo) r_lo <= rs_data_i;
      end
   end

   assign md_busy_o   = (r_state == ST_RUN) & w_core_busy;
   assign md_done_o   = (r_state == ST_DONE);
   assign hi_o        = r_hi;
   assign lo_o        = r_lo;
   assign hilo_data_o = (alu_function_i == FUNCT_MFHI) ? r_hi : r_lo;

endmodule

// File: tb/tb_alu_control_md.sv
// Directed bench for alu_control_md: decode sweep, MULT/DIV results and
// latency, divide by zero, pipeline hazards, reset abort and MTHI/MFHI.
module tb_alu_control_md;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_i;
   logic [2:0]  alu_op_i;
   logic [5:0]  alu_function_i;
   logic [31:0] rs_data_i, rt_data_i;
   logic [3:0]  alu_operation_o;
   logic        stall_o, md_busy_o, md_done_o;
   logic [31:0] hilo_data_o, hi_o, lo_o;

   int checks = 0;
   int errors = 0;

   alu_control_md #(.DATA_WIDTH(32), .ALU_OP_WIDTH(3)) dut (
      .clk             (clk),
      .reset           (reset),
      .valid_i         (valid_i),
      .alu_op_i        (alu_op_i),
      .alu_function_i  (alu_function_i),
      .rs_data_i       (rs_data_i),
      .rt_data_i       (rt_data_i),
      .alu_operation_o (alu_operation_o),
      .stall_o         (stall_o),
      .md_busy_o       (md_busy_o),
      .md_done_o       (md_done_o),
      .hilo_data_o     (hilo_data_o),
      .hi_o            (hi_o),
      .lo_o            (lo_o)
   );

   always #5 clk = ~clk;

   // Issue an MD op for one cycle, then count busy cycles until busy drops.
   task automatic run_md(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt,
                         output int busy_cycles);
      @(negedge clk);
      valid_i = 1'b1; alu_op_i = 3'b111; alu_function_i = fn;
      rs_data_i = rs; rt_data_i = rt;
      @(negedge clk);
      valid_i = 1'b0;
      busy_cycles = 0;
      while (md_busy_o && busy_cycles < 100) begin
         busy_cycles++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; valid_i = 1'b0; alu_op_i = 3'b000; alu_function_i = 6'h00;
      rs_data_i = '0; rt_data_i = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (hi_o !== 32'h0 || lo_o !== 32'h0 || md_busy_o !== 1'b0 || md_done_o !== 1'b0 || stall_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b stall=%b, want all zero",
                  hi_o, lo_o, md_busy_o, md_done_o, stall_o);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_decode;
      logic [2:0] ops [14];
      logic [5:0] fns [14];
      logic [3:0] exp [14];
      ops = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111,
              3'b111, 3'b111, 3'b100, 3'b001, 3'b010, 3'b011, 3'b111};
      fns = '{6'b100000, 6'b100010, 6'b100101, 6'b100100, 6'b101010, 6'b000000, 6'b000010,
              6'b010000, 6'b010010, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F};
      exp = '{4'b0011, 4'b0001, 4'b0010, 4'b0000, 4'b0101, 4'b0110, 4'b0111,
              4'b1000, 4'b1000, 4'b0011, 4'b0100, 4'b0010, 4'b0000, 4'b1001};
      valid_i = 1'b0;
      for (int i = 0; i < 14; i++) begin
         alu_op_i = ops[i]; alu_function_i = fns[i];
         #1;
         checks++;
         if (alu_operation_o !== exp[i]) begin
            errors++;
            $display("FAIL decode[%0d] op=%b fn=%b: got %b want %b", i, ops[i], fns[i], alu_operation_o, exp[i]);
         end
      end
      // MD and MT ops decode to the default code.
      alu_op_i = 3'b111; alu_function_i = 6'b011000; #1;
      checks++;
      if (alu_operation_o !== 4'b1001) begin
         errors++;
         $display("FAIL decode_mult: got %b want 1001", alu_operation_o);
      end
      alu_function_i = 6'b010001; #1;
      checks++;
      if (alu_operation_o !== 4'b1001) begin
         errors++;
         $display("FAIL decode_mthi: got %b want 1001", alu_operation_o);
      end
      @(negedge clk);
   endtask

   task automatic test_mult;
      int n;
      run_md(6'b011000, 32'hFFFFFFFE, 32'h00000003, n);
      checks++;
      if (n !== 32) begin
         errors++;
         $display("FAIL mult_busy_cycles: got %0d want 32", n);
      end
      checks++;
      if (md_done_o !== 1'b1 || hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFFA) begin
         errors++;
         $display("FAIL mult_result: done=%b hi=%h lo=%h want 1 ffffffff fffffffa", md_done_o, hi_o, lo_o);
      end
      @(negedge clk);
      checks++;
      if (md_done_o !== 1'b0) begin
         errors++;
         $display("FAIL mult_done_pulse: done=%b one cycle later, want 0", md_done_o);
      end
   endtask

   task automatic test_div;
      int n;
      run_md(6'b011010, 32'hFFFFFFF9, 32'h00000002, n);
      checks++;
      if (n !== 32 || hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFFD) begin
         errors++;
         $display("FAIL div_signed: n=%0d hi=%h lo=%h want 32 ffffffff fffffffd", n, hi_o, lo_o);
      end
      run_md(6'b011011, 32'hFFFFFFF9, 32'h00000002, n);
      checks++;
      if (hi_o !== 32'h00000001 || lo_o !== 32'h7FFFFFFC) begin
         errors++;
         $display("FAIL divu: hi=%h lo=%h want 00000001 7ffffffc", hi_o, lo_o);
      end
      run_md(6'b011010, 32'h80000000, 32'hFFFFFFFF, n);
      checks++;
      if (hi_o !== 32'h00000000 || lo_o !== 32'h80000000) begin
         errors++;
         $display("FAIL div_minneg: hi=%h lo=%h want 00000000 80000000", hi_o, lo_o);
      end
      run_md(6'b011010, 32'h00000064, 32'hFFFFFFF9, n);
      checks++;
      if (hi_o !== 32'h00000002 || lo_o !== 32'hFFFFFFF2) begin
         errors++;
         $display("FAIL div_neg_divisor: hi=%h lo=%h want 00000002 fffffff2", hi_o, lo_o);
      end
   endtask

   task automatic test_div_zero;
      int n;
      run_md(6'b011011, 32'h12345678, 32'h00000000, n);
      checks++;
      if (n !== 32 || md_done_o !== 1'b1 || hi_o !== 32'h12345678 || lo_o !== 32'hFFFFFFFF) begin
         errors++;
         $display("FAIL divu_zero: n=%0d done=%b hi=%h lo=%h want 32 1 12345678 ffffffff", n, md_done_o, hi_o, lo_o);
      end
      run_md(6'b011010, 32'hFFFFFFFB, 32'h00000000, n);
      checks++;
      if (n !== 32 || hi_o !== 32'hFFFFFFFB || lo_o !== 32'hFFFFFFFF) begin
         errors++;
         $display("FAIL div_zero: n=%0d hi=%h lo=%h want 32 fffffffb ffffffff", n, hi_o, lo_o);
      end
   endtask

   task automatic test_hazards;
      int n;
      // MULTU 5*7; ADD mid-run must not stall, MFLO must stall until DONE.
      @(negedge clk);
      valid_i = 1'b1; alu_op_i = 3'b111; alu_function_i = 6'b011001;
      rs_data_i = 32'd5; rt_data_i = 32'd7;
      @(negedge clk);
      alu_function_i = 6'b100000; #1;
      checks++;
      if (stall_o !== 1'b0 || alu_operation_o !== 4'b0011 || md_busy_o !== 1'b1) begin
         errors++;
         $display("FAIL add_during_run: stall=%b op=%b busy=%b want 0 0011 1", stall_o, alu_operation_o, md_busy_o);
      end
      @(negedge clk);
      alu_function_i = 6'b010010; #1;
      checks++;
      if (stall_o !== 1'b1) begin
         errors++;
         $display("FAIL mflo_stall: stall=%b want 1", stall_o);
      end
      n = 0;
      while (stall_o && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      checks++;
      if (n !== 31 || md_done_o !== 1'b1 || hilo_data_o !== 32'd35) begin
         errors++;
         $display("FAIL mflo_after_run: n=%0d done=%b hilo=%h want 31 1 00000023", n, md_done_o, hilo_data_o);
      end
      // Second MULTU issued during RUN is held, then accepted in DONE.
      @(negedge clk);
      alu_function_i = 6'b011001; rs_data_i = 32'h00010000; rt_data_i = 32'h00010000;
      @(negedge clk);
      rs_data_i = 32'd6; rt_data_i = 32'd7; #1;
      checks++;
      if (stall_o !== 1'b1) begin
         errors++;
         $display("FAIL multu_stall: stall=%b want 1", stall_o);
      end
      n = 0;
      while (stall_o && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      checks++;
      if (md_done_o !== 1'b1 || hi_o !== 32'h00000001 || lo_o !== 32'h00000000) begin
         errors++;
         $display("FAIL multu_big: done=%b hi=%h lo=%h want 1 00000001 00000000", md_done_o, hi_o, lo_o);
      end
      @(negedge clk);
      valid_i = 1'b0;
      checks++;
      if (md_busy_o !== 1'b1 || md_done_o !== 1'b0) begin
         errors++;
         $display("FAIL multu_accept_in_done: busy=%b done=%b want 1 0", md_busy_o, md_done_o);
      end
      n = 0;
      while (!md_done_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== 32 || hi_o !== 32'h0 || lo_o !== 32'd42) begin
         errors++;
         $display("FAIL multu_second: n=%0d hi=%h lo=%h want 32 00000000 0000002a", n, hi_o, lo_o);
      end
   endtask

   task automatic test_reset_abort;
      int seen_done;
      @(negedge clk);
      valid_i = 1'b1; alu_op_i = 3'b111; alu_function_i = 6'b011000;
      rs_data_i = 32'hFFFFFFFE; rt_data_i = 32'h00000003;
      @(negedge clk);
      valid_i = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1; #1;
      checks++;
      if (hi_o !== 32'h0 || lo_o !== 32'h0 || md_busy_o !== 1'b0 || md_done_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_midrun: hi=%h lo=%h busy=%b done=%b want 0 0 0 0", hi_o, lo_o, md_busy_o, md_done_o);
      end
      @(negedge clk);
      reset = 1'b0;
      seen_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (md_done_o || md_busy_o) seen_done++;
      end
      checks++;
      if (seen_done !== 0 || lo_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_discard: busy/done cycles=%0d lo=%h want 0 00000000", seen_done, lo_o);
      end
      // MTHI then MFHI, MTLO then MFLO.
      valid_i = 1'b1; alu_op_i = 3'b111; alu_function_i = 6'b010001; rs_data_i = 32'hA5A5A5A5;
      @(negedge clk);
      alu_function_i = 6'b010011; rs_data_i = 32'h3C3C3C3C;
      @(negedge clk);
      alu_function_i = 6'b010000; #1;
      checks++;
      if (hilo_data_o !== 32'hA5A5A5A5 || alu_operation_o !== 4'b1000) begin
         errors++;
         $display("FAIL mthi_mfhi: hilo=%h op=%b want a5a5a5a5 1000", hilo_data_o, alu_operation_o);
      end
      alu_function_i = 6'b010010; #1;
      checks++;
      if (hilo_data_o !== 32'h3C3C3C3C || hi_o !== 32'hA5A5A5A5) begin
         errors++;
         $display("FAIL mtlo_mflo: hilo=%h hi=%h want 3c3c3c3c a5a5a5a5", hilo_data_o, hi_o);
      end
      valid_i = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_decode();
      test_mult();
      test_div();
      test_div_zero();
      test_hazards();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_control_md.md
Name: alu_control_md

Overview:
- Next-generation ALU control for the MIPS datapath.
- Decodes {alu_op, function} into the 4-bit ALU operation code, as before, and extends the R-type set.
- Adds an iterative multiply/divide sequencer that owns the HI/LO registers and serves MFHI/MFLO/MTHI/MTLO.
- Raises a stall to the pipeline control while a multiply or divide is in flight.

Parameters:
- DATA_WIDTH, 32, operand, HI and LO width; must be even and at least 4.
- ALU_OP_WIDTH, 3, width of alu_op_i from the main control unit.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_i  input  1  instruction in decode stage is valid this cycle.
- alu_op_i  input  ALU_OP_WIDTH  op class from main control.
- alu_function_i  input  6  instruction funct field.
- rs_data_i  input  DATA_WIDTH  rs operand (dividend, multiplicand, or MTHI/MTLO source).
- rt_data_i  input  DATA_WIDTH  rt operand (divisor, multiplier).
- alu_operation_o  output  4  ALU operation code.
- stall_o  output  1  hold pipeline this cycle.
- md_busy_o  output  1  multiply/divide iteration in progress.
- md_done_o  output  1  one-cycle pulse after HI/LO update.
- hilo_data_o  output  DATA_WIDTH  HI (MFHI) or LO (MFLO) read data.
- hi_o  output  DATA_WIDTH  current HI.
- lo_o  output  DATA_WIDTH  current LO.

Behaviour:
- alu_operation_o is combinational and independent of valid_i.
- R-type (alu_op 111) encodings:
  - ADD 100000 -> 0011
  - SUB 100010 -> 0001
  - OR 100101 -> 0010
  - AND 100100 -> 0000
  - SLT 101010 -> 0101
  - SLL 000000 -> 0110
  - SRL 000010 -> 0111
  - MFHI 010000 / MFLO 010010 -> 1000 (pass hilo_data_o)
- I-type encodings, funct ignored: ADDI (100) -> 0011, LUI (001) -> 0100, ORI (010) -> 0010, ANDI (011) -> 0000.
- Anything else -> 1001, including MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- MD ops, all R-type: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
- HI/LO ops, all R-type: MFHI, MFLO, MTHI 010001, MTLO 010011.
- hilo_data_o = HI when funct is MFHI, else LO; combinational.
- FSM states:
  - IDLE -> RUN on a clock edge with valid_i=1, an MD op, and stall_o=0. At that edge, latch operand magnitudes, result-sign flags and op kind, and set count=DATA_WIDTH.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge; count decrements. The edge at which count==1 writes HI/LO and returns to DONE.
  - DONE: single cycle, md_done_o=1; next edge -> IDLE, or RUN directly if a new MD op is accepted.
- Latency: op accepted at edge k; md_busy_o=1 in cycles k+1..k+DATA_WIDTH; HI/LO valid from cycle k+DATA_WIDTH+1; md_done_o=1 in that cycle only.
- Multiply results:
  - {HI,LO} = full 2·DATA_WIDTH product.
  - MULT is signed: negate the magnitude product if the operand signs differ.
- Divide results:
  - LO = quotient, HI = remainder.
  - DIV: quotient is negative if signs differ; remainder takes the dividend's sign (truncating division).
  - DIV of most-negative by -1: LO = most-negative, HI = 0.
- Divide by zero, DIV or DIVU: no iteration skip, full latency; then HI = rs_data (as latched), LO = all ones.
- stall_o = valid_i & md_busy_o & (MD op | MFHI | MFLO | MTHI | MTLO). Non-HI/LO instructions never stall.
- MTHI/MTLO: when valid and not stalled, write rs_data_i to HI/LO at the clock edge. Same-cycle MFHI is impossible (single instruction per cycle).
- MFHI/MFLO in the DONE cycle return the new values without stalling.
- Reset (asynchronous, any state, including mid-RUN): state IDLE, count 0, HI=0, LO=0, md_busy_o=0, md_done_o=0, internal operands cleared. The aborted operation is discarded.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - ALU_OP_* classes (111, 100, 001, 010, 011)
  - FUNCT_* codes
  - ALU_CTL_* 4-bit operation codes
  - FSM state encoding (IDLE, RUN, DONE)
- One sub-module, md_iter_core: DATA_WIDTH-parameterised single-step shift-add / shift-subtract datapath with counter. The top level keeps decode, stall logic, sign fix-up and HI/LO.

Test Plan:
- Decode sweep: alu_op 111 with each listed funct, plus 100/001/010/011 with funct 6'h3F -> codes exactly as listed; alu_op 111 funct 6'h3F -> 1001.
- MULT, DATA_WIDTH=32: rs=0xFFFFFFFE (-2), rt=0x00000003 at edge k.
  - md_busy_o high 32 cycles.
  - Cycle k+33: HI=0xFFFFFFFF, LO=0xFFFFFFFA, md_done_o=1 for one cycle.
- DIV: rs=-7 (0xFFFFFFF9), rt=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU same operands -> LO=0x7FFFFFFC, HI=1.
- DIVU by zero: rs=0x12345678, rt=0 -> after 32 busy cycles HI=0x12345678, LO=0xFFFFFFFF.
- Hazards during RUN:
  - MFLO issued -> stall_o=1 until busy drops, then returns the new LO.
  - ADD issued -> stall_o=0, alu_operation_o=0011.
  - Second MULTU issued -> stalled, accepted in the DONE cycle.
- Reset at cycle 10 of a MULT -> HI=LO=0, busy=0 immediately, no md_done_o. MTHI rs=0xA5A5A5A5 then MFHI -> hilo_data_o=0xA5A5A5A5.
